// File: rtl/aes_defs.sv
// Shared AES encipher definitions: key-length encodings, round counts,
// control FSM states and the GF(2^8) round-transform helpers.
package aes_defs;

  localparam logic       AES_128_BIT_KEY = 1'h0;
  localparam logic       AES_256_BIT_KEY = 1'h1;
  localparam logic [3:0] AES128_ROUNDS   = 4'ha;
  localparam logic [3:0] AES256_ROUNDS   = 4'he;

  typedef enum logic [1:0] {
    CTRL_IDLE = 2'd0,
    CTRL_SBOX = 2'd1,
    CTRL_MAIN = 2'd2
  } ctrl_state_e;

  function automatic logic [7:0] gm2(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (8'h1b & {8{x[7]}});
  endfunction

  function automatic logic [7:0] gm3(input logic [7:0] x);
    return gm2(x) ^ x;
  endfunction

  // One state column {s0,s1,s2,s3}, row 0 in the MSB byte.
  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {gm2(a0) ^ gm3(a1) ^ a2 ^ a3,
            a0 ^ gm2(a1) ^ gm3(a2) ^ a3,
            a0 ^ a1 ^ gm2(a2) ^ gm3(a3),
            gm3(a0) ^ a1 ^ a2 ^ gm2(a3)};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    return {mix_column(s[127:96]), mix_column(s[95:64]),
            mix_column(s[63:32]), mix_column(s[31:0])};
  endfunction

  // Byte s(r,c) sits at bit 127-8*(4c+r); row r rotates left by r columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] t;
    t = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        t[127 - 8 * (4 * c + r) -: 8] = s[127 - 8 * (4 * ((c + r) % 4) + r) -: 8];
      end
    end
    return t;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box applied independently to the four bytes of a word.
module aes_sbox (
  input  logic [31:0] sword,
  output logic [31:0] new_sword
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign new_sword = {SBOX[sword[31:24]], SBOX[sword[23:16]],
                      SBOX[sword[15:8]],  SBOX[sword[7:0]]};

endmodule

// File: rtl/aes_encipher_block.sv
// Iterative AES encipher: one shared 32-bit S-box (four SBOX cycles per round)
// followed by a single MAIN cycle doing ShiftRows, MixColumns and AddRoundKey.
module aes_encipher_block
  import aes_defs::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         next,
  input  logic         keylen,
  output logic [3:0]   round,
  input  logic [127:0] round_key,
  input  logic [127:0] block,
  output logic [127:0] new_block,
  output logic         ready
);

  // Handshake: next is taken only on an edge where the FSM sits in IDLE; ready
  // falls on that edge and rises again on the edge that ends the final round,
  // from which point new_block holds the ciphertext until the next accept.

  ctrl_state_e  r_state, w_state_nxt;
  logic [127:0] r_block, w_block_nxt;
  logic [3:0]   r_round_ctr, w_round_nxt;
  logic [1:0]   r_sword_ctr, w_sword_nxt;
  logic         r_keylen, w_keylen_nxt;
  logic         r_ready, w_ready_nxt;

  logic [31:0]  w_sword, w_new_sword;
  logic [3:0]   w_num_rounds;
  logic [127:0] w_shifted;

  aes_sbox u_sbox (
    .sword     (w_sword),
    .new_sword (w_new_sword)
  );

  assign w_num_rounds = (r_keylen == AES_256_BIT_KEY) ? AES256_ROUNDS : AES128_ROUNDS;
  assign w_shifted    = shift_rows(r_block);

  assign round     = (r_state == CTRL_IDLE) ? 4'd0 : r_round_ctr;
  assign new_block = r_block;
  assign ready     = r_ready;

  always_comb begin
    w_sword = r_block[127:96];
    case (r_sword_ctr)
      2'd0:    w_sword = r_block[127:96];
      2'd1:    w_sword = r_block[95:64];
      2'd2:    w_sword = r_block[63:32];
      default: w_sword = r_block[31:0];
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= CTRL_IDLE;
      r_block     <= '0;
      r_round_ctr <= '0;
      r_sword_ctr <= '0;
      r_keylen    <= 1'b0;
      r_ready     <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_block     <= w_block_nxt;
      r_round_ctr <= w_round_nxt;
      r_sword_ctr <= w_sword_nxt;
      r_keylen    <= w_keylen_nxt;
      r_ready     <= w_ready_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_block_nxt  = r_block;
    w_round_nxt  = r_round_ctr;
    w_sword_nxt  = r_sword_ctr;
    w_keylen_nxt = r_keylen;
    w_ready_nxt  = r_ready;
    case (r_state)
      CTRL_IDLE: begin
        if (next) begin
          w_block_nxt  = block ^ round_key;
          w_keylen_nxt = keylen;
          w_round_nxt  = 4'd1;
          w_sword_nxt  = 2'd0;
          w_ready_nxt  = 1'b0;
          w_state_nxt  = CTRL_SBOX;
        end
      end
      CTRL_SBOX: begin
        case (r_sword_ctr)
          2'd0:    w_block_nxt[127:96] = w_new_sword;
          2'd1:    w_block_nxt[95:64]  = w_new_sword;
          2'd2:    w_block_nxt[63:32]  = w_new_sword;
          default: w_block_nxt[31:0]   = w_new_sword;
        endcase
        // Two-bit counter wraps back to 0 as the last word is substituted.
        w_sword_nxt = r_sword_ctr + 2'd1;
        if (r_sword_ctr == 2'd3) begin
          w_state_nxt = CTRL_MAIN;
        end
      end
      CTRL_MAIN: begin
        if (r_round_ctr < w_num_rounds) begin
          w_block_nxt = mix_columns(w_shifted) ^ round_key;
          w_round_nxt = r_round_ctr + 4'd1;
          w_state_nxt = CTRL_SBOX;
        end else begin
          w_block_nxt = w_shifted ^ round_key;
          w_round_nxt = 4'd0;
          w_ready_nxt = 1'b1;
          w_state_nxt = CTRL_IDLE;
        end
      end
      default: begin
        w_state_nxt = CTRL_IDLE;
        w_ready_nxt = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_aes_encipher_block.sv
// Bench for aes_encipher_block: FIPS-197 vectors plus random keys/plaintexts
// checked against a byte-level AES model with an algebraically derived S-box.
module tb_aes_encipher_block;

  logic         clk;
  logic         reset_n;
  logic         next;
  logic         keylen;
  logic [3:0]   round;
  logic [127:0] round_key;
  logic [127:0] block;
  logic [127:0] new_block;
  logic         ready;

  int checks = 0;
  int errors = 0;

  logic [127:0] exp_q[$];
  logic [127:0] rk_mem [16];
  logic [7:0]   sbox_tab [256];

  localparam logic [255:0] C1_KEY = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] C3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] C_PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] B_KEY  = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_R1   = 128'ha49c7ff2689f352b6b5bea43026a5049;

  aes_encipher_block dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .next      (next),
    .keylen    (keylen),
    .round     (round),
    .round_key (round_key),
    .block     (block),
    .new_block (new_block),
    .ready     (ready)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Key memory: expanded key for the requested round, combinationally.
  assign round_key = rk_mem[round];

  // Reference model
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic       hi;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b  = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0) begin
        inv = 8'h01;
        for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(x));
      end
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
              ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox_tab[x] = s;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
  endfunction

  task automatic load_key(input logic [255:0] key, input logic kl);
    logic [31:0] w [60];
    logic [31:0] tmp;
    logic [7:0]  rc;
    int nk, nr;
    nk = kl ? 8 : 4;
    nr = kl ? 14 : 10;
    rc = 8'h01;
    for (int i = 0; i < 60; i++) w[i] = 32'h0;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32 * i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      tmp = w[i - 1];
      if (i % nk == 0) begin
        tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        tmp = sub_word(tmp);
      end
      w[i] = w[i - nk] ^ tmp;
    end
    for (int r = 0; r < 16; r++) begin
      rk_mem[r] = (r <= nr) ? {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]} : 128'h0;
    end
  endtask

  task automatic model_encrypt(input logic kl, input logic [127:0] pt,
                               output logic [127:0] ct, output logic [127:0] r1);
    logic [127:0] st, nx;
    logic [7:0]   mcoef [4];
    logic [7:0]   acc;
    int nr;
    mcoef[0] = 8'h02; mcoef[1] = 8'h03; mcoef[2] = 8'h01; mcoef[3] = 8'h01;
    nr = kl ? 14 : 10;
    r1 = 128'h0;
    st = pt ^ rk_mem[0];
    for (int rd = 1; rd <= nr; rd++) begin
      for (int b = 0; b < 16; b++) st[127 - 8 * b -: 8] = sbox_tab[st[127 - 8 * b -: 8]];
      nx = 128'h0;
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          nx[127 - 8 * (4 * c + r) -: 8] = st[127 - 8 * (4 * ((c + r) % 4) + r) -: 8];
      st = nx;
      if (rd < nr) begin
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++) begin
            acc = 8'h00;
            for (int k = 0; k < 4; k++)
              acc = acc ^ gmul(mcoef[(k - r + 4) % 4], st[127 - 8 * (4 * c + k) -: 8]);
            nx[127 - 8 * (4 * c + r) -: 8] = acc;
          end
        st = nx;
      end
      st = st ^ rk_mem[rd];
      if (rd == 1) r1 = st;
    end
    ct = st;
  endtask

  // Scoreboard compare
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Driver: start an operation (key memory already loaded) and follow it to done.
  task automatic run_op(input logic kl, input logic [127:0] pt, input logic [127:0] exp_ct,
                        input logic [127:0] exp_r1, input bit noise, input string tag);
    int   n, cyc;
    logic rnd_ok;
    n = kl ? 14 : 10;
    exp_q.push_back(exp_ct);
    next   = 1'b1;
    block  = pt;
    keylen = kl;
    @(posedge clk); #1;
    next   = 1'b0;
    cyc    = 0;
    rnd_ok = 1'b1;
    while (ready !== 1'b1 && cyc < 200) begin
      cyc++;
      if (round !== 4'((cyc - 1) / 5 + 1)) rnd_ok = 1'b0;
      if (cyc == 6) check({tag, "_round1"}, new_block, exp_r1);
      if (noise) begin
        next   = 1'b1;
        block  = {$urandom(), $urandom(), $urandom(), $urandom()};
        keylen = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
    end
    next = 1'b0;
    check({tag, "_latency"}, 128'(cyc), 128'(5 * n));
    check({tag, "_round_seq"}, 128'(rnd_ok), 128'd1);
    check({tag, "_round_idle"}, 128'(round), 128'd0);
    check({tag, "_result"}, new_block, exp_q.pop_front());
  endtask

  task automatic idle_check(input logic [127:0] exp, input string tag);
    @(posedge clk); #1;
    check({tag, "_hold_ready"}, 128'(ready), 128'd1);
    check({tag, "_hold_block"}, new_block, exp);
  endtask

  initial begin
    logic [255:0] key;
    logic [127:0] pt, ct, r1;
    logic         kl;

    for (int i = 0; i < 16; i++) rk_mem[i] = 128'h0;
    build_sbox();
    reset_n = 1'b0;
    next    = 1'b0;
    keylen  = 1'b0;
    block   = 128'h0;

    #12;
    check("rst_ready", 128'(ready), 128'd1);
    check("rst_block", new_block, 128'h0);
    check("rst_round", 128'(round), 128'd0);
    #5 reset_n = 1'b1;
    @(posedge clk); #1;

    // FIPS-197 C.1 then C.3 accepted one cycle after C.1 completes
    load_key(C1_KEY, 1'b0);
    model_encrypt(1'b0, C_PT, ct, r1);
    run_op(1'b0, C_PT, C1_CT, r1, 1'b0, "c1");
    load_key(C3_KEY, 1'b1);
    model_encrypt(1'b1, C_PT, ct, r1);
    run_op(1'b1, C_PT, C3_CT, r1, 1'b0, "c3");

    // FIPS-197 Appendix B with its published round-1 state
    load_key(B_KEY, 1'b0);
    run_op(1'b0, B_PT, B_CT, B_R1, 1'b0, "fipsb");

    // Inputs churn and next held high while busy, including the completion edge
    load_key(C1_KEY, 1'b0);
    model_encrypt(1'b0, C_PT, ct, r1);
    run_op(1'b0, C_PT, C1_CT, r1, 1'b1, "busy");
    idle_check(C1_CT, "busy");

    // Asynchronous reset in the middle of a C.1 run
    next   = 1'b1;
    block  = C_PT;
    keylen = 1'b0;
    @(posedge clk); #1;
    next = 1'b0;
    repeat (22) begin
      @(posedge clk); #1;
    end
    #2 reset_n = 1'b0;
    #1;
    check("midrst_ready", 128'(ready), 128'd1);
    check("midrst_block", new_block, 128'h0);
    check("midrst_round", 128'(round), 128'd0);
    #2 reset_n = 1'b1;
    @(posedge clk); #1;
    run_op(1'b0, C_PT, C1_CT, r1, 1'b0, "post_rst");

    // Random keys, key lengths and plaintexts against the model
    for (int i = 0; i < 6; i++) begin
      key = {$urandom(), $urandom(), $urandom(), $urandom(),
             $urandom(), $urandom(), $urandom(), $urandom()};
      kl  = 1'($urandom_range(0, 1));
      pt  = {$urandom(), $urandom(), $urandom(), $urandom()};
      load_key(key, kl);
      model_encrypt(kl, pt, ct, r1);
      run_op(kl, pt, ct, r1, (i % 2) == 1, $sformatf("rnd%0d", i));
    end
    idle_check(ct, "final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
